// File: rtl/picomem2wb.sv
// picomem2wb: CPU native memory interface to Wishbone classic master bridge with bus timeout
module picomem2wb #(
   parameter int                ASIZE    = 14,
   parameter int                DSIZE    = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DSIZE-1:0]  ERR_DATA = 32'hDEADBEEF
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_mem_valid,
   input  logic [31:0]        i_mem_addr,
   input  logic [DSIZE-1:0]   i_mem_wdata,
   input  logic [3:0]         i_mem_wstrb,
   output logic               o_mem_ready,
   output logic [DSIZE-1:0]   o_mem_rdata,
   output logic               o_mem_err,
   output logic [ASIZE-1:0]   o_wb_adr,
   output logic               o_wb_cyc,
   output logic               o_wb_stb,
   output logic               o_wb_we,
   output logic [3:0]         o_wb_sel,
   output logic [DSIZE-1:0]   o_wb_dat,
   input  logic               i_wb_ack,
   input  logic [DSIZE-1:0]   i_wb_dat
);
   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             stb_q;
   logic             we_q;
   logic             ready_q;
   logic             err_q;
   logic [ASIZE-1:0] adr_q;
   logic [3:0]       sel_q;
   logic [DSIZE-1:0] dat_q;
   logic [DSIZE-1:0] rdata_q;
   logic             wr;
   logic             unused_addr;

   assign wr          = |i_mem_wstrb;
   assign unused_addr = ^{i_mem_addr[31:ASIZE+2], i_mem_addr[1:0]};

   assign o_mem_ready = ready_q;
   assign o_mem_rdata = rdata_q;
   assign o_mem_err   = err_q;
   assign o_wb_adr    = adr_q;
   assign o_wb_cyc    = stb_q;
   assign o_wb_stb    = stb_q;
   assign o_wb_we     = we_q;
   assign o_wb_sel    = sel_q;
   assign o_wb_dat    = dat_q;

   // Request latch, Wishbone cycle, ack/timeout completion and one-cycle ready pulse
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_mem_valid) begin
                  state_q <= BUS;
                  adr_q   <= i_mem_addr[ASIZE+1:2];
                  we_q    <= wr;
                  sel_q   <= wr ? i_mem_wstrb : 4'b1111;
                  dat_q   <= wr ? i_mem_wdata : '0;
                  stb_q   <= 1'b1;
               end
            end
            BUS: begin
               cnt_q <= cnt_q + CW'(1);
               if (i_wb_ack) begin
                  rdata_q <= we_q ? '0 : i_wb_dat;
                  stb_q   <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= DONE;
               end else if (cnt_q == TLIM) begin
                  rdata_q <= we_q ? '0 : ERR_DATA;
                  stb_q   <= 1'b0;
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_picomem2wb.sv
// tb_picomem2wb: directed bench for picomem2wb against a behavioural Wishbone SRAM with programmable ack delay
module tb_picomem2wb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        ready;
   logic [31:0] rdata;
   logic        err;
   logic [13:0] wb_adr;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] wb_dat;
   logic        ack = 1'b0;
   logic [31:0] wb_rdat = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:16383];
   int          wait_n = 1;
   bit          no_ack = 1'b0;
   int          wcnt = 0;

   int          lat, stb_n;
   bit          got_ready, stable;
   logic [13:0] adr_c;
   logic [3:0]  sel_c;
   logic        we_c;
   logic [31:0] dat_c, rdata_c;
   logic        err_c;
   int          extra;

   picomem2wb #(.ASIZE(14), .DSIZE(32), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mem_valid(valid), .i_mem_addr(addr),
      .i_mem_wdata(wdata), .i_mem_wstrb(wstrb), .o_mem_ready(ready),
      .o_mem_rdata(rdata), .o_mem_err(err), .o_wb_adr(wb_adr), .o_wb_cyc(cyc),
      .o_wb_stb(stb), .o_wb_we(we), .o_wb_sel(sel), .o_wb_dat(wb_dat),
      .i_wb_ack(ack), .i_wb_dat(wb_rdat)
   );

   always #5 clk = ~clk;

   // SRAM slave: acks wait_n edges after stb rises, applies byte-selected writes
   always @(posedge clk) begin
      if (stb && !ack && !no_ack) begin
         if (wcnt + 1 >= wait_n) begin
            ack     <= 1'b1;
            wcnt    <= 0;
            wb_rdat <= mem[wb_adr];
            if (we)
               for (int i = 0; i < 4; i++)
                  if (sel[i]) mem[wb_adr][8*i +: 8] <= wb_dat[8*i +: 8];
         end else wcnt <= wcnt + 1;
      end else begin
         ack  <= 1'b0;
         wcnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request at a negedge and tracks it until ready (bounded)
   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      addr = a; wdata = d; wstrb = s; valid = 1'b1;
      lat = 0; stb_n = 0; got_ready = 1'b0; stable = 1'b1;
      while (!got_ready && lat < 40) begin
         @(negedge clk);
         lat++;
         if (stb) begin
            if (stb_n == 0) begin
               adr_c = wb_adr; sel_c = sel; we_c = we; dat_c = wb_dat;
            end else if (wb_adr !== adr_c || sel !== sel_c || cyc !== 1'b1) stable = 1'b0;
            stb_n++;
         end
         if (ready) begin
            got_ready = 1'b1; rdata_c = rdata; err_c = err;
         end
      end
      valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      mem[14'h0010] = 32'h1234ABCD;
      mem[14'h3FFF] = 32'hDCBADCBA;
      mem[14'h0020] = 32'hCAFEF00D;
      mem[14'h0030] = 32'h0BADF00D;

      repeat (3) @(negedge clk);
      chk("rst_outs", {ready, err, cyc, stb, we, sel, wb_adr}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_wbdat", wb_dat, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      req(32'h0000_0040, 32'h0, 4'h0);
      chk("rd_ready", 32'(got_ready), 32'd1);
      chk("rd_adr", 32'(adr_c), 32'h0010);
      chk("rd_sel_we", {27'h0, we_c, sel_c}, {27'h0, 1'b0, 4'b1111});
      chk("rd_dat0", dat_c, 32'h0);
      chk("rd_stb_n", 32'(stb_n), 32'd2);
      chk("rd_lat", 32'(lat), 32'd3);
      chk("rd_rdata", rdata_c, 32'h1234ABCD);
      chk("rd_err", 32'(err_c), 32'd0);
      @(negedge clk);
      chk("rd_pulse", 32'(ready), 32'd0);

      req(32'hFFFF_0043, 32'h0, 4'h0);
      chk("hi_adr", 32'(adr_c), 32'h0010);
      chk("hi_rdata", rdata_c, 32'h1234ABCD);
      @(negedge clk);

      req(32'h0000_FFFC, 32'hFFFFFFFF, 4'b0001);
      chk("bw_adr", 32'(adr_c), 32'h3FFF);
      chk("bw_sel_we", {27'h0, we_c, sel_c}, {27'h0, 1'b1, 4'b0001});
      chk("bw_dat", dat_c, 32'hFFFFFFFF);
      chk("bw_rdata0", rdata_c, 32'h0);
      @(negedge clk);
      req(32'h0000_FFFC, 32'h0, 4'h0);
      chk("bw_readback", rdata_c, 32'hDCBADCFF);
      @(negedge clk);

      req(32'h0000_0000, 32'hA5A55A5A, 4'hF);
      chk("b2b_wr_lat", 32'(lat), 32'd3);
      req(32'h0000_0000, 32'h0, 4'h0);
      chk("b2b_period", 32'(lat), 32'd4);
      chk("b2b_stb_n", 32'(stb_n), 32'd2);
      chk("b2b_rdata", rdata_c, 32'hA5A55A5A);
      @(negedge clk);
      chk("b2b_pulse", 32'(ready), 32'd0);

      wait_n = 5;
      req(32'h0000_0080, 32'h0, 4'h0);
      chk("ws_stb_n", 32'(stb_n), 32'd6);
      chk("ws_stable", 32'(stable), 32'd1);
      chk("ws_lat", 32'(lat), 32'd7);
      chk("ws_rdata", rdata_c, 32'hCAFEF00D);
      chk("ws_err", 32'(err_c), 32'd0);
      @(negedge clk);

      no_ack = 1'b1;
      req(32'h0000_00C0, 32'h0, 4'h0);
      chk("to_ready", 32'(got_ready), 32'd1);
      chk("to_stb_n", 32'(stb_n), 32'd8);
      chk("to_lat", 32'(lat), 32'd9);
      chk("to_err", 32'(err_c), 32'd1);
      chk("to_rdata", rdata_c, 32'hDEADBEEF);
      @(negedge clk);
      chk("to_pulse", {30'h0, ready, err}, 32'h0);
      no_ack = 1'b0;
      wait_n = 1;
      req(32'h0000_00C0, 32'h0, 4'h0);
      chk("to_after_err", 32'(err_c), 32'd0);
      chk("to_after_rdata", rdata_c, 32'h0BADF00D);
      @(negedge clk);

      wait_n = 5;
      addr = 32'h0000_0040; wstrb = 4'h0; valid = 1'b1;
      @(negedge clk);
      chk("mr_in_bus", 32'(stb), 32'd1);
      rst_n = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("mr_outs", {ready, err, cyc, stb, we, sel, wb_adr}, 32'h0);
      chk("mr_rdata", rdata, 32'h0);
      rst_n = 1'b1; wait_n = 1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready || stb) extra++;
      end
      chk("mr_no_ready", 32'(extra), 32'd0);
      req(32'h0000_0040, 32'h0, 4'h0);
      chk("mr_lat", 32'(lat), 32'd3);
      chk("mr_rdata2", rdata_c, 32'h1234ABCD);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
